tis_node_ctrl: RTL

Execution sequencer for one TIS-100 compute node. Owns the program counter and walks the program. Resolves jumps (JMP/Jcc/JRO) from the decoded opcode, ACC and jump operand. Stalls on blocking port reads/writes through valid/ack handshakes, and emits the commit strobe that gates the ACC/BAK datapath and the instr_rom fetch.

---
 rtl/tis_pkg.sv | 28 ++
 rtl/tis_pc_next.sv | 66 ++++++
 rtl/tis_node_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/tis_pkg.sv
// Shared opcode codes, FSM state encoding and default widths for one TIS-100 node.
package tis_pkg;

    localparam int unsigned PC_W_DEF   = 4;
    localparam int unsigned DATA_W_DEF = 11;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_SWP = 4'd2;
    localparam logic [3:0] OP_SAV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JEZ = 4'd8;
    localparam logic [3:0] OP_JNZ = 4'd9;
    localparam logic [3:0] OP_JGZ = 4'd10;
    localparam logic [3:0] OP_JLZ = 4'd11;
    localparam logic [3:0] OP_JRO = 4'd12;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_IDLE  = 2'd3
    } state_e;

endpackage

// File: rtl/tis_pc_next.sv
// Combinational next-pc: sequential wrap, conditional/absolute jumps and clamped JRO.
module tis_pc_next
    import tis_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   prog_len,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] jmp_off,
    output logic [PC_W-1:0]   pc_nxt
);

    // One extra bit so pc + offset cannot overflow before clamping.
    localparam int unsigned SUM_W = DATA_W + 1;

    logic [PC_W:0]       pc_inc;
    logic [PC_W-1:0]     seq_pc;
    logic [SUM_W-1:0]    abs_tgt;
    logic [SUM_W-1:0]    rel_tgt;
    logic [PC_W-1:0]     abs_pc;
    logic [PC_W-1:0]     rel_pc;
    logic                acc_zero;
    logic                acc_neg;
    logic                take;

    // Two's-complement target clamped into [0, len-1].
    function automatic logic [PC_W-1:0] clamp(input logic [SUM_W-1:0] t,
                                              input logic [PC_W-1:0]  len);
        if (t[SUM_W-1])
            return '0;
        else if (t >= {{(SUM_W-PC_W){1'b0}}, len})
            return (len == '0) ? '0 : len - PC_W'(1);
        else
            return t[PC_W-1:0];
    endfunction

    assign pc_inc   = {1'b0, pc} + (PC_W+1)'(1);
    assign seq_pc   = (pc_inc >= {1'b0, prog_len}) ? '0 : pc_inc[PC_W-1:0];
    assign abs_tgt  = {jmp_off[DATA_W-1], jmp_off};
    assign rel_tgt  = abs_tgt + {{(SUM_W-PC_W){1'b0}}, pc};
    assign abs_pc   = clamp(abs_tgt, prog_len);
    assign rel_pc   = clamp(rel_tgt, prog_len);
    assign acc_zero = (acc == '0);
    assign acc_neg  = acc[DATA_W-1];

    always_comb begin
        take   = 1'b0;
        pc_nxt = seq_pc;
        case (op)
            OP_JMP:  take = 1'b1;
            OP_JEZ:  take = acc_zero;
            OP_JNZ:  take = !acc_zero;
            OP_JGZ:  take = !acc_zero && !acc_neg;
            OP_JLZ:  take = acc_neg;
            default: take = 1'b0;
        endcase
        if (op == OP_JRO)
            pc_nxt = rel_pc;
        else if (take)
            pc_nxt = abs_pc;
    end

endmodule

// File: rtl/tis_node_ctrl.sv
// TIS-100 node sequencer: pc ownership, port read/write stalls and commit strobe.
module tis_node_ctrl
    import tis_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [PC_W-1:0]   prog_len,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] jmp_off,
    input  logic              src_is_port,
    input  logic              dst_is_port,
    input  logic              rd_valid,
    input  logic              wr_ready,
    output logic [PC_W-1:0]   pc,
    output logic              rd_ack,
    output logic              wr_valid,
    output logic              exec_en,
    output logic [1:0]        state
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_nxt;
    logic            wr_valid_q, wr_valid_d;

    tis_pc_next #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_pc_next (
        .pc       (pc_q),
        .prog_len (prog_len),
        .op       (op),
        .acc      (acc),
        .jmp_off  (jmp_off),
        .pc_nxt   (pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (prog_len == '0) ? ST_IDLE : ST_RUN;
            pc_q       <= '0;
            wr_valid_q <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    // Next state, handshake strobes and commit; nothing happens while frozen or in reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_ack  = 1'b0;
        exec_en = 1'b0;
        if (clk_en && !reset) begin
            if (prog_len == '0) begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_RUN;
                        pc_d    = '0;
                    end
                    ST_WRITE: begin
                        if (wr_ready) begin
                            exec_en = 1'b1;
                            pc_d    = pc_nxt;
                            state_d = ST_RUN;
                        end
                    end
                    default: begin
                        if (src_is_port && !rd_valid) begin
                            state_d = ST_READ;
                        end else begin
                            rd_ack = src_is_port;
                            if (dst_is_port) begin
                                state_d = ST_WRITE;
                            end else begin
                                exec_en = 1'b1;
                                pc_d    = pc_nxt;
                                state_d = ST_RUN;
                            end
                        end
                    end
                endcase
            end
        end
        wr_valid_d = (state_d == ST_WRITE);
    end

    assign pc       = pc_q;
    assign wr_valid = wr_valid_q;
    assign state    = state_q;

endmodule
